// File: rtl/mem_stage.sv
// Memory-access stage of the RV32 pipeline: data-memory handshake, store lane steering,
// load extraction and the MEM/WB register. Optional MEM_MISALIGN_CHECK_EN adds misalign_o.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_reg_wr,
  input  logic              ex_dm2reg,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [2:0]        ex_funct3,
  input  logic [REG_W-1:0]  ex_rd_addr,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_rs2_data,
  output logic              dm_req,
  output logic [3:0]        dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              stall_o,
  output logic              wb_reg_wr,
  output logic              wb_dm2reg,
  output logic [REG_W-1:0]  wb_rd_addr,
  output logic [DATA_W-1:0] wb_rd_data,
  output logic [DATA_W-1:0] wb_dm_out
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic              mem_op, mem_go, is_store, is_load, misalign, load_done;
  logic [1:0]        lane;
  logic [7:0]        rd_bytes [4];
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  assign lane     = ex_alu_out[1:0];
  assign mem_op   = ex_valid & (ex_mem_rd | ex_mem_wr);
  // A simultaneous load+store is treated as a store.
  assign is_store = ex_mem_wr;
  assign is_load  = ex_mem_rd & ~ex_mem_wr;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = mem_op & (((ex_funct3[1:0] == 2'b01) & lane[0]) |
                              ((ex_funct3[1:0] == 2'b10) & (lane != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign mem_go    = mem_op & ~misalign;
  assign stall_o   = mem_go & ~dm_ack;
  assign load_done = mem_go & is_load & dm_ack;
  assign dm_addr   = {ex_alu_out[DATA_W-1:2], 2'b00};

  always_comb begin
    state_next = state_reg;
    dm_req     = 1'b0;
    case (state_reg)
      IDLE: begin
        dm_req = mem_go;
        if (mem_go && !dm_ack) state_next = WAIT;
      end
      WAIT: begin
        dm_req = 1'b1;
        if (dm_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dm_we    = 4'b0000;
    dm_wdata = ex_rs2_data;
    case (ex_funct3)
      3'b000: begin
        dm_wdata = {4{ex_rs2_data[7:0]}};
        if (mem_go && is_store) dm_we = 4'b0001 << lane;
      end
      3'b001: begin
        dm_wdata = {2{ex_rs2_data[15:0]}};
        if (mem_go && is_store) dm_we = 4'b0011 << {lane[1], 1'b0};
      end
      3'b010: begin
        if (mem_go && is_store) dm_we = 4'b1111;
      end
      default: dm_we = 4'b0000;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_bytes[gi] = dm_rdata[8*gi +: 8];
  end

  assign ld_byte = rd_bytes[lane];
  assign ld_half = lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    ld_ext = '0;
    case (ex_funct3)
      3'b000:  ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b001:  ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
      3'b010:  ld_ext = dm_rdata;
      default: ld_ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      wb_reg_wr  <= 1'b0;
      wb_dm2reg  <= 1'b0;
      wb_rd_addr <= '0;
      wb_rd_data <= '0;
      wb_dm_out  <= '0;
    end else begin
      state_reg <= state_next;
      if (stall_o) begin
        wb_reg_wr <= 1'b0;
      end else begin
        wb_reg_wr  <= ex_valid & ex_reg_wr & ~misalign;
        wb_dm2reg  <= ex_dm2reg;
        wb_rd_addr <= ex_rd_addr;
        wb_rd_data <= ex_alu_out;
        if (load_done) wb_dm_out <= ld_ext;
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= misalign;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle accesses plus wait-state,
// reset-in-WAIT and misaligned-access sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_wr, ex_dm2reg, ex_mem_rd, ex_mem_wr;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_alu_out, ex_rs2_data;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall_o;
  logic        wb_reg_wr, wb_dm2reg;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data, wb_dm_out;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr), .ex_dm2reg(ex_dm2reg),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
    .ex_rd_addr(ex_rd_addr), .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_o(stall_o),
    .wb_reg_wr(wb_reg_wr), .wb_dm2reg(wb_dm2reg), .wb_rd_addr(wb_rd_addr),
    .wb_rd_data(wb_rd_data), .wb_dm_out(wb_dm_out)
`ifdef MEM_MISALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );

  typedef struct {
    logic        v, rw, d2r, rd, wr;
    logic [2:0]  f3;
    logic [4:0]  rda;
    logic [31:0] alu, rs2;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_stall;
    logic        e_wrw, e_wd2r;
    logic [4:0]  e_wrda;
    logic [31:0] e_wrdata, e_wdmout;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic d2r, input logic rd,
                       input logic wr, input logic [2:0] f3, input logic [4:0] rda,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input logic ack, input logic [31:0] rdata);
    ex_valid = v; ex_reg_wr = rw; ex_dm2reg = d2r; ex_mem_rd = rd; ex_mem_wr = wr;
    ex_funct3 = f3; ex_rd_addr = rda; ex_alu_out = alu; ex_rs2_data = rs2;
    dm_ack = ack; dm_rdata = rdata;
  endtask

  task automatic chk_wb_zero(input string tag);
    chk({tag, "_wb_reg_wr"}, {31'b0, wb_reg_wr}, 32'h0);
    chk({tag, "_wb_dm2reg"}, {31'b0, wb_dm2reg}, 32'h0);
    chk({tag, "_wb_rd_addr"}, {27'b0, wb_rd_addr}, 32'h0);
    chk({tag, "_wb_rd_data"}, wb_rd_data, 32'h0);
    chk({tag, "_wb_dm_out"}, wb_dm_out, 32'h0);
  endtask

  // Byte load with three wait states; ack arrives on the fourth cycle.
  task automatic lb_wait(input logic [2:0] f3, input logic [31:0] exp_out, input string tag);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive(1, 1, 1, 1, 0, f3, 5'd3, 32'h203, 32'h0, (c == 4), 32'h80FF_0000);
      #1;
      chk({tag, "_req"}, {31'b0, dm_req}, 32'h1);
      chk({tag, "_addr"}, dm_addr, 32'h200);
      chk({tag, "_stall"}, {31'b0, stall_o}, {31'b0, (c != 4)});
      @(posedge clk); #1;
      chk({tag, "_wb_reg_wr"}, {31'b0, wb_reg_wr}, {31'b0, (c == 4)});
    end
    chk({tag, "_wb_dm_out"}, wb_dm_out, exp_out);
    $display("seq %s: wb_dm_out=0x%08h", tag, wb_dm_out);
  endtask

  initial begin
    vecs[0]  = '{1,1,1,1,0,3'd2,5'd5,32'h104,32'h0,1,32'hDEADBEEF, 1,4'h0,32'h104,32'h0,0, 1,1,5'd5,32'h104,32'hDEADBEEF};
    vecs[1]  = '{1,0,0,0,1,3'd1,5'd0,32'h102,32'h1234ABCD,1,32'h0, 1,4'hC,32'h100,32'hABCDABCD,0, 0,0,5'd0,32'h102,32'hDEADBEEF};
    vecs[2]  = '{1,1,0,0,0,3'd0,5'd7,32'h55,32'h11,1,32'h12345678, 0,4'h0,32'h54,32'h11111111,0, 1,0,5'd7,32'h55,32'hDEADBEEF};
    vecs[3]  = '{1,0,0,0,1,3'd0,5'd0,32'h301,32'hA5,1,32'h0, 1,4'h2,32'h300,32'hA5A5A5A5,0, 0,0,5'd0,32'h301,32'hDEADBEEF};
    vecs[4]  = '{1,0,0,0,1,3'd2,5'd0,32'h400,32'hCAFEF00D,1,32'h0, 1,4'hF,32'h400,32'hCAFEF00D,0, 0,0,5'd0,32'h400,32'hDEADBEEF};
    vecs[5]  = '{1,0,0,0,1,3'd1,5'd0,32'h100,32'h0000BEEF,1,32'h0, 1,4'h3,32'h100,32'hBEEFBEEF,0, 0,0,5'd0,32'h100,32'hDEADBEEF};
    vecs[6]  = '{1,1,1,1,0,3'd1,5'd9,32'h206,32'h0,1,32'h80017FFF, 1,4'h0,32'h204,32'h0,0, 1,1,5'd9,32'h206,32'hFFFF8001};
    vecs[7]  = '{1,1,1,1,0,3'd5,5'd10,32'h208,32'h0,1,32'h8001F00F, 1,4'h0,32'h208,32'h0,0, 1,1,5'd10,32'h208,32'h0000F00F};
    vecs[8]  = '{1,1,1,1,0,3'd0,5'd11,32'h10,32'h0,1,32'h1234567F, 1,4'h0,32'h10,32'h0,0, 1,1,5'd11,32'h10,32'h0000007F};
    vecs[9]  = '{0,1,1,1,0,3'd2,5'd12,32'h20,32'h0,1,32'hFFFFFFFF, 0,4'h0,32'h20,32'h0,0, 0,1,5'd12,32'h20,32'h0000007F};
    vecs[10] = '{1,1,1,1,0,3'd3,5'd13,32'h30,32'h0,1,32'h12345678, 1,4'h0,32'h30,32'h0,0, 1,1,5'd13,32'h30,32'h0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req", {31'b0, dm_req}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk_wb_zero("rst");
`ifdef MEM_MISALIGN_CHECK_EN
    chk("rst_misalign", {31'b0, misalign_o}, 32'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rw, vecs[i].d2r, vecs[i].rd, vecs[i].wr, vecs[i].f3,
            vecs[i].rda, vecs[i].alu, vecs[i].rs2, vecs[i].ack, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, dm_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_we", i), {28'b0, dm_we}, {28'b0, vecs[i].e_we});
      chk($sformatf("v%0d_addr", i), dm_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_wdata", i), dm_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_stall", i), {31'b0, stall_o}, {31'b0, vecs[i].e_stall});
      @(posedge clk); #1;
      chk($sformatf("v%0d_wb_reg_wr", i), {31'b0, wb_reg_wr}, {31'b0, vecs[i].e_wrw});
      chk($sformatf("v%0d_wb_dm2reg", i), {31'b0, wb_dm2reg}, {31'b0, vecs[i].e_wd2r});
      chk($sformatf("v%0d_wb_rd_addr", i), {27'b0, wb_rd_addr}, {27'b0, vecs[i].e_wrda});
      chk($sformatf("v%0d_wb_rd_data", i), wb_rd_data, vecs[i].e_wrdata);
      chk($sformatf("v%0d_wb_dm_out", i), wb_dm_out, vecs[i].e_wdmout);
      $display("vec %0d: addr=0x%08h we=%b wdata=0x%08h wb_rd_data=0x%08h wb_dm_out=0x%08h",
               i, dm_addr, dm_we, dm_wdata, wb_rd_data, wb_dm_out);
    end

    lb_wait(3'd0, 32'hFFFFFF80, "lb_wait");
    lb_wait(3'd4, 32'h00000080, "lbu_wait");

    // Reset while waiting: request dropped, late ack ignored.
    @(negedge clk);
    drive(1, 1, 1, 1, 0, 3'd2, 5'd4, 32'h500, 32'h0, 0, 32'h0);
    #1;
    chk("rstw_stall", {31'b0, stall_o}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_wb_zero("rstw");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 1, 32'hFFFFFFFF);
    #1;
    chk("rstw_idle_req", {31'b0, dm_req}, 32'h0);
    chk("rstw_idle_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    chk("rstw_late_ack_dm_out", wb_dm_out, 32'h0);
    chk("rstw_late_ack_reg_wr", {31'b0, wb_reg_wr}, 32'h0);
    $display("seq reset_in_wait: dm_req=%b wb_dm_out=0x%08h", dm_req, wb_dm_out);

`ifdef MEM_MISALIGN_CHECK_EN
    @(negedge clk);
    drive(1, 1, 1, 1, 0, 3'd2, 5'd6, 32'h102, 32'h0, 0, 32'h0);
    #1;
    chk("mis_req", {31'b0, dm_req}, 32'h0);
    chk("mis_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    chk("mis_flag", {31'b0, misalign_o}, 32'h1);
    chk("mis_wb_reg_wr", {31'b0, wb_reg_wr}, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    @(posedge clk); #1;
    chk("mis_flag_drop", {31'b0, misalign_o}, 32'h0);
    $display("seq misalign: LW at 0x102 flagged");
`else
    // Misaligned half load at lane 3 uses the upper half.
    @(negedge clk);
    drive(1, 1, 1, 1, 0, 3'd1, 5'd6, 32'h203, 32'h0, 1, 32'hFF80_1234);
    #1;
    chk("mis_req", {31'b0, dm_req}, 32'h1);
    chk("mis_addr", dm_addr, 32'h200);
    @(posedge clk); #1;
    chk("mis_wb_reg_wr", {31'b0, wb_reg_wr}, 32'h1);
    chk("mis_dm_out", wb_dm_out, 32'hFFFFFF80);
    $display("seq misaligned_lh: wb_dm_out=0x%08h", wb_dm_out);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
